// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/ack channel, decode-side
// instruction handshake and the redirect (flush) inputs.
//   master : the fetch unit (drives imem_req/imem_addr and the instr_* outputs)
//   slave  : memory + decode + branch environment
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a 2-entry FIFO instruction buffer.
// Issues one word-aligned read at a time to instruction memory, queues the
// returned words with their PCs and presents the head to decode.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (imem_req/addr/ack/rdata, instr_valid/out/pc/
//           ready, redirect/redirect_pc)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] addr_q, addr_nx;
  logic        req_q, req_nx;
  logic [1:0]  count, count_nx;
  logic        rd_ptr, wr_ptr;
  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic        push, pop;

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr_out   = buf_instr[rd_ptr];
  assign bus.instr_pc    = buf_pc[rd_ptr];

  always_comb begin
    push = (state == FETCH) && req_q && bus.imem_ack && !bus.redirect &&
           (count != FULL);
    pop  = bus.instr_valid && bus.instr_ready;

    count_nx = count;
    if (bus.redirect)
      count_nx = 2'd0;
    else if (push && !pop)
      count_nx = count + 2'd1;
    else if (!push && pop)
      count_nx = count - 2'd1;

    fetch_pc_nx = fetch_pc;
    if (bus.redirect)
      fetch_pc_nx = {bus.redirect_pc[31:2], 2'b00};
    else if (push)
      fetch_pc_nx = fetch_pc + 32'd4;

    state_nx = state;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: if (bus.redirect && req_q && !bus.imem_ack) state_nx = DROP;
      DROP:  if (req_q && bus.imem_ack) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase

    // Request is registered: computed from next-cycle state/count so it is
    // already consistent with the gating rule on the cycle it is visible.
    // An outstanding request can only be released by its ack, since count
    // never grows without one.
    if (state == IDLE)
      req_nx = 1'b0;
    else if (state_nx == DROP)
      req_nx = 1'b1;
    else
      req_nx = (count_nx != FULL);

    // DROP keeps presenting the abandoned address until its ack arrives.
    addr_nx = (state_nx == DROP) ? addr_q : fetch_pc_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= '0;
      req_q    <= 1'b0;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      addr_q   <= addr_nx;
      req_q    <= req_nx;
      count    <= count_nx;
      if (push) begin
        buf_instr[wr_ptr] <= bus.imem_rdata;
        buf_pc[wr_ptr]    <= fetch_pc;
      end
      if (bus.redirect) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule
